// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one request at a time
// to a variable-latency instruction memory, buffers returned words in a small
// circular FIFO and presents the head to IF/ID as {pc+4, instruction}.
// A MEM-stage redirect flushes the FIFO and restarts fetch at the target; a
// request that is still waiting for its ack is completed and its data thrown
// away (DROP state) instead of being abandoned mid-handshake.
//
// Handshakes:
//   memory side : a transfer happens on a rising edge where imem_req_o and
//                 imem_ack_i are both 1; imem_addr_o is held while req is
//                 high and no ack has arrived.
//   IF/ID side  : the head is consumed on a rising edge where instr_valid_o
//                 is 1 and stall_i is 0; while stalled the head is held.

module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_data_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    input  logic                     stall_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc4_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    buf_instr [DEPTH];
    logic [31:0]    buf_pc4   [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic           push;
    logic           pop;
    logic [CW-1:0]  count_next;
    logic           room;
    logic [31:0]    redirect_target;
    logic [31:0]    pc_plus4;

    // Push/pop decisions and the occupancy the FSM will see after this edge.
    always_comb begin
        push            = imem_req_o & imem_ack_i & (state == S_FETCH) & ~redirect_i;
        pop             = instr_valid_o & ~stall_i & ~redirect_i;
        count_next      = count + CW'(push) - CW'(pop);
        room            = (count_next < CW'(DEPTH));
        redirect_target = redirect_pc_i & ~32'h0000_0003;
        pc_plus4        = fetch_pc + 32'd4;
    end

    // FIFO storage, pointers and occupancy; a redirect empties the queue and
    // cancels any push or pop in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc4[i]   <= 32'd0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= imem_data_i;
                buf_pc4[wr_ptr]   <= pc_plus4;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    // Fetch FSM with registered request/address and the fetch PC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            fetch_pc    <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_target;
            if ((state == S_DROP) || ((state == S_FETCH) && !imem_ack_i)) begin
                // A request is still waiting: keep it on the bus, discard later.
                state <= S_DROP;
            end else begin
                state       <= S_FETCH;
                imem_req_o  <= 1'b1;
                imem_addr_o <= redirect_target;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (room) begin
                        state       <= S_FETCH;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= fetch_pc;
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        fetch_pc <= pc_plus4;
                        if (room) begin
                            imem_addr_o <= pc_plus4;
                        end else begin
                            state      <= S_IDLE;
                            imem_req_o <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        state       <= S_FETCH;
                        imem_addr_o <= fetch_pc;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

    assign instr_valid_o = (count != '0);
    assign instr_o       = buf_instr[rd_ptr];
    assign pc4_o         = buf_pc4[rd_ptr];
    assign count_o       = count;
    assign state_o       = state;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue. A reference model predicts the
// instruction stream as a plain address sequence (start address, +4, +8, ...)
// restarted by every reset or redirect; a monitor compares each consumed head
// against that prediction. A memory model answers requests with
// addr ^ 32'hA5A5_0000 at a configurable or random latency.

module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        stall_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc4_o;
    logic [2:0]  count_o;
    logic [1:0]  state_dbg;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc4_o        (pc4_o),
        .count_o      (count_o),
        .state_o      (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    int          checks  = 0;
    int          errors  = 0;
    int          accepts = 0;
    int          max_count = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;

    // Memory model controls.
    int          mem_lat  = 0;
    bit          mem_rand = 0;
    int          wait_cnt = 0;
    bit          p_req    = 0;
    bit          p_ack    = 0;
    logic [31:0] p_addr   = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back({model_pc + 32'd4, model_pc ^ KEY});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void flush_model(input logic [31:0] start);
        exp_q.delete();
        model_pc = start & ~32'h0000_0003;
        top_up();
    endfunction

    // Driver timing: inputs change 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accepts(input int n, input int budget, input string name);
        int target;
        int c;
        target = accepts + n;
        c = 0;
        while (accepts < target && c < budget) begin
            step();
            c++;
        end
        chk(name, 64'(accepts >= target), 64'd1);
    endtask

    // Memory model: answers after mem_lat wait cycles (or randomly) and checks
    // that a pending request keeps its address.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            imem_ack_i = 1'b0;
            wait_cnt   = 0;
            p_req      = 0;
            p_ack      = 0;
        end else begin
            bit go;
            if (p_req && !p_ack && imem_req_o)
                chk("addr_stable", imem_addr_o, p_addr);
            if (imem_req_o) begin
                go = mem_rand ? ($urandom_range(0, 2) == 0) : (wait_cnt >= mem_lat);
                if (go) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = imem_addr_o ^ KEY;
                    wait_cnt    = 0;
                end else begin
                    imem_ack_i  = 1'b0;
                    imem_data_i = $urandom;
                    wait_cnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                wait_cnt   = 0;
            end
            p_req  = imem_req_o;
            p_ack  = imem_ack_i;
            p_addr = imem_addr_o;
        end
    end

    // Monitor: on every cycle the head is consumed, compare it against the
    // predicted stream.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            chk("valid_vs_count", 64'(instr_valid_o), 64'(count_o != 3'd0));
            chk("count_bound", 64'(count_o <= 3'(DEPTH)), 64'd1);
            if (int'(count_o) > max_count) max_count = int'(count_o);
            if (instr_valid_o && !stall_i && !redirect_i) begin
                if (exp_q.size() == 0) top_up();
                e = exp_q.pop_front();
                chk("stream", {pc4_o, instr_o}, e);
                accepts++;
                top_up();
            end
        end
    end

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        flush_model(tgt);
    endtask

    // Main sequence.
    initial begin
        logic [63:0] head;
        logic [31:0] stale;
        logic [31:0] tgt;
        int          c;
        int          start_acc;

        flush_model(RESET_PC);
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(imem_req_o), 64'd0);
        chk("rst_valid", 64'(instr_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_head", {pc4_o, instr_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // First request on the first edge, first instruction on the second.
        step();
        chk("first_req", 64'(imem_req_o), 64'd1);
        chk("first_addr", imem_addr_o, RESET_PC);
        step();
        chk("first_valid", 64'(instr_valid_o), 64'd1);
        chk("first_pc4", pc4_o, RESET_PC + 32'd4);

        // Zero-wait stream, no stall: occupancy stays at one.
        max_count = 0;
        wait_accepts(20, 40, "stream_progress");
        chk("stream_max_count", max_count, 64'd1);

        // Backpressure: queue fills to DEPTH, request drops, head held.
        stall_i = 1'b1;
        head = {pc4_o, instr_o};
        repeat (10) step();
        chk("bp_count", 64'(count_o), 64'(DEPTH));
        chk("bp_req", 64'(imem_req_o), 64'd0);
        chk("bp_head", {pc4_o, instr_o}, head);
        stall_i = 1'b0;
        wait_accepts(12, 40, "bp_resume");

        // Slow memory: ack every third cycle.
        mem_lat = 2;
        wait_accepts(10, 80, "slow_progress");

        // Redirect coincident with an ack: that data is dropped.
        mem_lat = 0;
        c = 0;
        while (!(imem_req_o && imem_ack_i) && c < 20) begin step(); c++; end
        chk("rack_setup", 64'(imem_req_o && imem_ack_i), 64'd1);
        do_redirect(32'h0000_4000);
        step();
        redirect_i = 1'b0;
        chk("rack_count", 64'(count_o), 64'd0);
        chk("rack_valid", 64'(instr_valid_o), 64'd0);
        chk("rack_addr", imem_addr_o, 32'h0000_4000);
        wait_accepts(5, 20, "rack_progress");

        // Redirect on a full queue coincident with a pop.
        stall_i = 1'b1;
        repeat (8) step();
        chk("rfull_setup", 64'(count_o), 64'(DEPTH));
        stall_i = 1'b0;
        do_redirect(32'h0000_5000);
        step();
        redirect_i = 1'b0;
        chk("rpop_count", 64'(count_o), 64'd0);
        chk("rpop_valid", 64'(instr_valid_o), 64'd0);
        chk("rpop_req", 64'(imem_req_o), 64'd1);
        chk("rpop_addr", imem_addr_o, 32'h0000_5000);
        wait_accepts(5, 20, "rpop_progress");

        // Redirect on a full queue while stalled.
        stall_i = 1'b1;
        repeat (8) step();
        do_redirect(32'h0000_6002);
        step();
        redirect_i = 1'b0;
        chk("rstall_count", 64'(count_o), 64'd0);
        chk("rstall_addr", imem_addr_o, 32'h0000_6000);
        stall_i = 1'b0;
        wait_accepts(5, 20, "rstall_progress");

        // Redirect while a slow request is still waiting for its ack.
        mem_lat = 2;
        c = 0;
        while (!(imem_req_o && !imem_ack_i) && c < 20) begin step(); c++; end
        chk("rfly_setup", 64'(imem_req_o && !imem_ack_i), 64'd1);
        stale = imem_addr_o;
        do_redirect(32'h0000_0103);
        step();
        redirect_i = 1'b0;
        chk("rfly_count", 64'(count_o), 64'd0);
        chk("rfly_valid", 64'(instr_valid_o), 64'd0);
        chk("rfly_req", 64'(imem_req_o), 64'd1);
        chk("rfly_stale_addr", imem_addr_o, stale);
        c = 0;
        while (imem_addr_o == stale && c < 20) begin step(); c++; end
        chk("rfly_new_addr", imem_addr_o, 32'h0000_0100);
        c = 0;
        while (!instr_valid_o && c < 20) begin step(); c++; end
        chk("rfly_first_pc4", pc4_o, 32'h0000_0104);
        wait_accepts(4, 40, "rfly_progress");

        // Randomized traffic: random stalls, random memory, random redirects.
        mem_rand  = 1;
        start_acc = accepts;
        for (int i = 0; i < 1500; i++) begin
            stall_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'($urandom);
                do_redirect(tgt);
            end else begin
                redirect_i = 1'b0;
            end
            step();
        end
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        chk("rand_progress", 64'((accepts - start_acc) > 100), 64'd1);
        wait_accepts(5, 60, "rand_drain");

        // Asynchronous reset between edges.
        mem_rand = 0;
        mem_lat  = 0;
        repeat (3) step();
        #1;
        rst = 1'b1;
        flush_model(RESET_PC);
        #1;
        chk("arst_req", 64'(imem_req_o), 64'd0);
        chk("arst_valid", 64'(instr_valid_o), 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst_restart_req", 64'(imem_req_o), 64'd1);
        chk("arst_restart_addr", imem_addr_o, RESET_PC);
        wait_accepts(8, 20, "arst_progress");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
